// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit feeding the HI/LO registers; raises busy to stall the front end.
// Optional MULDIV_FAST_MUL_EN: MUL/MULU use a single-cycle multiplier and skip the iterative phase.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_opa;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    // Operand decode: sign flags and magnitudes captured on start.
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_fast_sel;

    assign w_is_div = op[1];
    assign w_a_neg  = op[0] & opa[WIDTH-1];
    assign w_b_neg  = op[0] & opb[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -opa : opa;
    assign w_mag_b  = w_b_neg ? -opb : opb;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_sel  = ~op[1];
    assign w_fast_prod = (2*WIDTH)'(w_mag_a) * (2*WIDTH)'(w_mag_b);
`else
    assign w_fast_sel  = 1'b0;
`endif

    logic w_capture;
    logic w_step;
    logic w_finish;

    assign w_capture = (r_state == IDLE) & start & ~flush;
    assign w_step    = (r_state == CALC) & ~flush;
    assign w_finish  = (r_state == FIN)  & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through this block leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_fast_sel ? FIN : CALC;
            CALC:    if (r_cnt == LAST_STEP) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    // MUL step: acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // DIV step: acc holds {remainder, dividend/quotient}; remainder needs one extra bit after the shift.
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_ge   = w_rem_sh >= {1'b0, r_mcand};
    assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_mcand;
    assign w_div_next = w_rem_ge ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                                 : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign fix-up applied on the FIN cycle.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_res_hi = r_opa;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_opa      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= w_finish;
            if (w_capture) begin
                r_cnt      <= '0;
                r_is_div   <= w_is_div;
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_is_div & w_a_neg;
                r_div_zero <= w_is_div & (opb == '0);
                r_opa      <= opa;
                r_mcand    <= w_is_div ? w_mag_b : w_mag_a;
`ifdef MULDIV_FAST_MUL_EN
                r_acc      <= w_fast_sel ? w_fast_prod
                                         : {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
`else
                r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
`endif
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= r_is_div ? w_div_next : w_mul_next;
            end
            if (w_finish) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
